// File: rtl/turn_signal_monitor.sv
// Passive monitor for the six turn-signal lamp lines.
// The monitor registers one lamp sample, then classifies it on the following
// edge. It tracks the decoded mode, sweep and flash counts, and pattern or
// transition errors. Outputs follow a lamp change by two edges.
module turn_signal_monitor #(
   parameter int unsigned CW        = 8,
   parameter int unsigned IDLE_CYC  = 4,
   parameter int unsigned STUCK_MAX = 16
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          L1,
   input  logic          L2,
   input  logic          L3,
   input  logic          R1,
   input  logic          R2,
   input  logic          R3,
   input  logic          err_clr,
   output logic [1:0]    mode,
   output logic [CW-1:0] left_sweeps,
   output logic [CW-1:0] right_sweeps,
   output logic [CW-1:0] emer_flashes,
   output logic          err,
   output logic [2:0]    err_code,
   output logic [CW-1:0] err_cnt
);

   localparam int unsigned IW = $clog2(IDLE_CYC + 1);
   localparam int unsigned SW = $clog2(STUCK_MAX + 1);

   typedef enum logic [3:0] {
      C_OFF, C_LA, C_LB, C_LC, C_RA, C_RB, C_RC, C_EMER, C_BAD
   } cls_e;

   typedef enum logic [1:0] {
      M_IDLE  = 2'b00,
      M_LEFT  = 2'b01,
      M_RIGHT = 2'b10,
      M_EMER  = 2'b11
   } mode_e;

   logic [5:0]    sample_q;
   cls_e          prev_q, prev_d;
   cls_e          cur;
   mode_e         mode_q, mode_d;
   logic [IW-1:0] idle_q, idle_d;
   logic [SW-1:0] hold_q, hold_d;
   logic [CW-1:0] left_q, left_d;
   logic [CW-1:0] right_q, right_d;
   logic [CW-1:0] flash_q, flash_d;
   logic [CW-1:0] err_cnt_q, err_cnt_d;
   logic          err_q, err_d;
   logic [2:0]    err_code_q, err_code_d;
   logic          stuck;
   logic          legal;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == '1) ? v : v + CW'(1);
   endfunction

   function automatic logic is_legal(input cls_e p, input cls_e c);
      logic ok;
      case (p)
         C_OFF:   ok = c inside {C_OFF, C_LA, C_RA, C_EMER};
         C_EMER:  ok = (c == C_OFF);
         C_LA:    ok = c inside {C_LA, C_LB, C_OFF, C_EMER};
         C_LB:    ok = c inside {C_LB, C_LC, C_OFF, C_EMER};
         C_LC:    ok = c inside {C_OFF, C_EMER};
         C_RA:    ok = c inside {C_RA, C_RB, C_OFF, C_EMER};
         C_RB:    ok = c inside {C_RB, C_RC, C_OFF, C_EMER};
         C_RC:    ok = c inside {C_OFF, C_EMER};
         default: ok = 1'b1;
      endcase
      return ok;
   endfunction

   // Decode the registered lamp vector {L1,L2,L3,R1,R2,R3} into a pattern class
   always_comb begin
      cur = C_BAD;
      case (sample_q)
         6'b000000: cur = C_OFF;
         6'b100000: cur = C_LA;
         6'b110000: cur = C_LB;
         6'b111000: cur = C_LC;
         6'b000100: cur = C_RA;
         6'b000110: cur = C_RB;
         6'b000111: cur = C_RC;
         6'b111111: cur = C_EMER;
         default:   cur = C_BAD;
      endcase
   end

   // Next-state logic: transition check, hold/idle counters, mode, event counters, errors
   always_comb begin
      prev_d     = cur;
      mode_d     = mode_q;
      idle_d     = idle_q;
      hold_d     = '0;
      left_d     = left_q;
      right_d    = right_q;
      flash_d    = flash_q;
      err_d      = 1'b0;
      err_code_d = err_code_q;
      err_cnt_d  = err_cnt_q;
      legal      = is_legal(prev_q, cur);

      // Only the held patterns (LA/LB/RA/RB) count toward stuck.
      if (cur inside {C_LA, C_LB, C_RA, C_RB}) begin
         if (cur == prev_q)
            hold_d = (hold_q == SW'(STUCK_MAX)) ? hold_q : hold_q + SW'(1);
         else
            hold_d = SW'(1);
      end
      // Fire only on the edge where the count first reaches the limit.
      stuck = (hold_d == SW'(STUCK_MAX)) && (hold_q != SW'(STUCK_MAX));

      case (cur)
         C_LA, C_LB, C_LC: begin
            mode_d = M_LEFT;
            idle_d = '0;
         end
         C_RA, C_RB, C_RC: begin
            mode_d = M_RIGHT;
            idle_d = '0;
         end
         C_EMER: begin
            mode_d = M_EMER;
            idle_d = '0;
         end
         C_OFF: begin
            idle_d = (idle_q == IW'(IDLE_CYC)) ? idle_q : idle_q + IW'(1);
            if (idle_d == IW'(IDLE_CYC))
               mode_d = M_IDLE;
         end
         default: idle_d = '0;
      endcase

      if (prev_q == C_LB && cur == C_LC)
         left_d = sat_inc(left_q);
      if (prev_q == C_RB && cur == C_RC)
         right_d = sat_inc(right_q);
      if (prev_q == C_OFF && cur == C_EMER)
         flash_d = sat_inc(flash_q);

      // A new error takes precedence over err_clr on the same edge.
      if (cur == C_BAD || !legal || stuck) begin
         err_d     = 1'b1;
         err_cnt_d = sat_inc(err_cnt_q);
         if (cur == C_BAD)
            err_code_d = 3'd1;
         else if (!legal)
            err_code_d = 3'd2;
         else
            err_code_d = 3'd3;
      end else if (err_clr) begin
         err_code_d = 3'd0;
      end
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge Clk) begin
      if (Rst) begin
         sample_q   <= '0;
         prev_q     <= C_OFF;
         mode_q     <= M_IDLE;
         idle_q     <= '0;
         hold_q     <= '0;
         left_q     <= '0;
         right_q    <= '0;
         flash_q    <= '0;
         err_q      <= 1'b0;
         err_code_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         sample_q   <= {L1, L2, L3, R1, R2, R3};
         prev_q     <= prev_d;
         mode_q     <= mode_d;
         idle_q     <= idle_d;
         hold_q     <= hold_d;
         left_q     <= left_d;
         right_q    <= right_d;
         flash_q    <= flash_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign mode         = mode_q;
   assign left_sweeps  = left_q;
   assign right_sweeps = right_q;
   assign emer_flashes = flash_q;
   assign err          = err_q;
   assign err_code     = err_code_q;
   assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_turn_signal_monitor.sv
// Directed bench for turn_signal_monitor.
// dut1 uses the default parameters. dut2 uses CW=2 for the saturation and
// mid-operation reset cases. After each step, the outputs reflect the
// vector applied in the previous step.
module tb_turn_signal_monitor;

   localparam logic [5:0] OFF = 6'b000000;
   localparam logic [5:0] LA  = 6'b100000;
   localparam logic [5:0] LB  = 6'b110000;
   localparam logic [5:0] LC  = 6'b111000;
   localparam logic [5:0] RA  = 6'b000100;
   localparam logic [5:0] EM  = 6'b111111;
   localparam logic [5:0] BAD = 6'b101010;

   logic       Clk = 1'b0;
   logic       rst1, rst2;
   logic       L1, L2, L3, R1, R2, R3;
   logic       err_clr;

   logic [1:0] mode1, mode2;
   logic [7:0] lsw1, rsw1, fl1, ecnt1;
   logic [1:0] lsw2, rsw2, fl2, ecnt2;
   logic       err1, err2;
   logic [2:0] ecode1, ecode2;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 Clk = ~Clk;

   turn_signal_monitor #(.CW(8), .IDLE_CYC(4), .STUCK_MAX(16)) dut1 (
      .Clk(Clk), .Rst(rst1), .L1(L1), .L2(L2), .L3(L3), .R1(R1), .R2(R2), .R3(R3),
      .err_clr(err_clr), .mode(mode1), .left_sweeps(lsw1), .right_sweeps(rsw1),
      .emer_flashes(fl1), .err(err1), .err_code(ecode1), .err_cnt(ecnt1)
   );

   turn_signal_monitor #(.CW(2), .IDLE_CYC(4), .STUCK_MAX(16)) dut2 (
      .Clk(Clk), .Rst(rst2), .L1(L1), .L2(L2), .L3(L3), .R1(R1), .R2(R2), .R3(R3),
      .err_clr(err_clr), .mode(mode2), .left_sweeps(lsw2), .right_sweeps(rsw2),
      .emer_flashes(fl2), .err(err2), .err_code(ecode2), .err_cnt(ecnt2)
   );

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step(input logic [5:0] v, input logic clr);
      @(negedge Clk);
      {L1, L2, L3, R1, R2, R3} = v;
      err_clr = clr;
      @(posedge Clk);
      #1;
   endtask

   logic [5:0] t1_v [7] = '{OFF, LA, LB, LC, OFF, OFF, OFF};
   int unsigned t1_mode [7] = '{0, 0, 1, 1, 1, 1, 1};
   int unsigned t1_lsw [7]  = '{0, 0, 0, 0, 1, 1, 1};
   logic [5:0] t2_v [8] = '{OFF, EM, OFF, EM, OFF, OFF, OFF, OFF};
   int unsigned t2_mode [8] = '{1, 0, 3, 3, 3, 3, 3, 3};
   int unsigned t2_fl [8]   = '{0, 0, 1, 1, 2, 2, 2, 2};

   initial begin
      rst1 = 1'b1;
      rst2 = 1'b1;
      err_clr = 1'b0;
      {L1, L2, L3, R1, R2, R3} = OFF;
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_mode", mode1, 0);
      chk("rst_lsw", lsw1, 0);
      chk("rst_rsw", rsw1, 0);
      chk("rst_flash", fl1, 0);
      chk("rst_err", err1, 0);
      chk("rst_code", ecode1, 0);
      chk("rst_ecnt", ecnt1, 0);
      rst1 = 1'b0;

      // A full left sweep followed by three OFF samples
      for (int i = 0; i < 7; i++) begin
         step(t1_v[i], 1'b0);
         chk("t1_mode", mode1, t1_mode[i]);
         chk("t1_lsw", lsw1, t1_lsw[i]);
         chk("t1_err", err1, 0);
      end

      // Emergency flashes with OFF gaps, then four OFF samples back to IDLE
      for (int i = 0; i < 8; i++) begin
         step(t2_v[i], 1'b0);
         chk("t2_mode", mode1, t2_mode[i]);
         chk("t2_flash", fl1, t2_fl[i]);
         chk("t2_err", err1, 0);
      end

      // An illegal pattern, then resync on RA
      step(BAD, 1'b0);
      chk("t3_idle_mode", mode1, 0);
      step(RA, 1'b0);
      chk("t3_bad_err", err1, 1);
      chk("t3_bad_code", ecode1, 1);
      chk("t3_bad_cnt", ecnt1, 1);
      chk("t3_bad_mode", mode1, 0);
      step(OFF, 1'b0);
      chk("t3_resync_err", err1, 0);
      chk("t3_resync_mode", mode1, 2);
      chk("t3_code_hold", ecode1, 1);

      // LC->LC and EMER->EMER illegal transitions
      step(LA, 1'b0);
      step(LB, 1'b0);
      step(LC, 1'b0);
      step(LC, 1'b0);
      chk("t4_lsw", lsw1, 2);
      chk("t4_lb_lc_err", err1, 0);
      step(OFF, 1'b0);
      chk("t4_lclc_err", err1, 1);
      chk("t4_lclc_code", ecode1, 2);
      chk("t4_lclc_cnt", ecnt1, 2);
      chk("t4_lsw_hold", lsw1, 2);
      step(EM, 1'b0);
      chk("t4_lcoff_err", err1, 0);
      step(EM, 1'b0);
      chk("t4_flash", fl1, 3);
      step(OFF, 1'b0);
      chk("t4_emem_err", err1, 1);
      chk("t4_emem_code", ecode1, 2);
      chk("t4_emem_cnt", ecnt1, 3);
      chk("t4_flash_hold", fl1, 3);
      step(OFF, 1'b1);
      chk("t4_clr_code", ecode1, 0);
      chk("t4_clr_cnt", ecnt1, 3);

      // Hold LA for 20 samples; stuck fires only on the 16th
      for (int k = 1; k <= 20; k++) begin
         step(LA, 1'b0);
         if (k >= 2) begin
            chk("t5_err", err1, (k == 17) ? 1 : 0);
            if (k == 17) begin
               chk("t5_stuck_code", ecode1, 3);
               chk("t5_stuck_cnt", ecnt1, 4);
            end
         end
      end
      step(OFF, 1'b0);
      chk("t5_tail_err", err1, 0);
      chk("t5_tail_cnt", ecnt1, 4);
      step(BAD, 1'b0);
      chk("t5_laoff_err", err1, 0);
      step(OFF, 1'b1);
      chk("t5_clr_vs_err", err1, 1);
      chk("t5_clr_vs_code", ecode1, 1);
      chk("t5_clr_vs_cnt", ecnt1, 5);
      step(OFF, 1'b0);
      chk("t5_post_err", err1, 0);
      chk("t5_post_code", ecode1, 1);

      // CW=2 instance: saturation and mid-sweep reset
      rst2 = 1'b0;
      step(OFF, 1'b0);
      for (int s = 1; s <= 5; s++) begin
         step(LA, 1'b0);
         step(LB, 1'b0);
         step(LC, 1'b0);
         step(OFF, 1'b0);
         chk("t6_lsw_sat", lsw2, (s < 3) ? s : 3);
      end
      step(OFF, 1'b0);
      chk("t6_ecnt", ecnt2, 0);
      chk("t6_mode", mode2, 1);
      step(LA, 1'b0);
      step(LB, 1'b0);
      chk("t6_pre_rst_mode", mode2, 1);
      rst2 = 1'b1;
      step(LC, 1'b0);
      chk("t6_rst_mode", mode2, 0);
      chk("t6_rst_lsw", lsw2, 0);
      chk("t6_rst_flash", fl2, 0);
      chk("t6_rst_err", err2, 0);
      chk("t6_rst_code", ecode2, 0);
      chk("t6_rst_ecnt", ecnt2, 0);
      rst2 = 1'b0;
      step(LB, 1'b0);
      chk("t6_post_rst_err", err2, 0);
      step(OFF, 1'b0);
      chk("t6_offlb_err", err2, 1);
      chk("t6_offlb_code", ecode2, 2);
      chk("t6_offlb_cnt", ecnt2, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
